// File: rtl/multi_ch_pattern_engine.sv
// Multi-channel serial pattern engine: shadow config per channel, and a commit
// that starts every armed channel on the same edge, each with FAST/SLOW bit periods.
module multi_ch_pattern_engine #(
    parameter int DATA_BIT = 32,
    parameter int CH_NUM   = 16,
    parameter int CH_BIT   = 4,
    parameter int FAST_DIV = 4,
    parameter int SLOW_DIV = 16,
    parameter int DIV_BIT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [CH_BIT-1:0]   i_cfg_sel,
    input  logic [DATA_BIT-1:0] i_cfg_output,
    input  logic [DATA_BIT-1:0] i_cfg_freq,
    input  logic                i_cfg_mode,
    input  logic                i_cfg_arm,
    input  logic                i_commit,
    input  logic [CH_NUM-1:0]   i_stop,
    output logic [CH_NUM-1:0]   o_serial_out,
    output logic [CH_NUM-1:0]   o_busy,
    output logic [CH_NUM-1:0]   o_done_tick
);

    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BIT - 1);
    localparam logic [DIV_BIT-1:0] FAST_LD  = DIV_BIT'(FAST_DIV - 1);
    localparam logic [DIV_BIT-1:0] SLOW_LD  = DIV_BIT'(SLOW_DIV - 1);

    typedef enum logic {S_IDLE, S_COMMIT} ctrl_state_e;
    typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;

    ctrl_state_e state_q, state_d;
    logic        cfg_accept;
    logic        commit_fire;

    // Period counter counts down to zero, so it is loaded with (period - 1).
    function automatic logic [DIV_BIT-1:0] period_ld(input logic fast);
        return fast ? FAST_LD : SLOW_LD;
    endfunction

    always_comb begin
        state_d     = state_q;
        o_cfg_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_cfg_ready = 1'b1;
                if (i_commit) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cfg_accept  = i_cfg_valid & o_cfg_ready;
    assign commit_fire = (state_q == S_COMMIT);

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DATA_BIT-1:0] sh_out_q, sh_freq_q;
            logic                sh_mode_q, arm_q;
            logic                sel_hit;

            // Selects at or above CH_NUM match no channel and are dropped.
            assign sel_hit = cfg_accept && (i_cfg_sel == CH_BIT'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sh_out_q  <= '0;
                    sh_freq_q <= '0;
                    sh_mode_q <= 1'b0;
                    arm_q     <= 1'b0;
                end else if (sel_hit) begin
                    sh_out_q  <= i_cfg_output;
                    sh_freq_q <= i_cfg_freq;
                    sh_mode_q <= i_cfg_mode;
                    arm_q     <= i_cfg_arm;
                end else if (commit_fire) begin
                    arm_q <= 1'b0;
                end
            end

            ch_state_e           ch_state_q, ch_state_d;
            logic [DATA_BIT-1:0] act_out_q, act_out_d;
            logic [DATA_BIT-1:0] act_freq_q, act_freq_d;
            logic                act_mode_q, act_mode_d;
            logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx;
            logic [DIV_BIT-1:0]  cnt_q, cnt_d;
            logic                ser_q, ser_d;
            logic                done_q, done_d;

            assign nxt_idx = idx_q + 1'b1;

            always_comb begin
                ch_state_d = ch_state_q;
                act_out_d  = act_out_q;
                act_freq_d = act_freq_q;
                act_mode_d = act_mode_q;
                idx_d      = idx_q;
                cnt_d      = cnt_q;
                ser_d      = ser_q;
                done_d     = 1'b0;
                // Stop outranks both a commit restart and a frame end.
                if (i_stop[gi]) begin
                    ch_state_d = CH_IDLE;
                    ser_d      = 1'b0;
                end else if (commit_fire && arm_q) begin
                    ch_state_d = CH_RUN;
                    act_out_d  = sh_out_q;
                    act_freq_d = sh_freq_q;
                    act_mode_d = sh_mode_q;
                    idx_d      = '0;
                    cnt_d      = period_ld(sh_freq_q[0]);
                    ser_d      = sh_out_q[0];
                end else if (ch_state_q == CH_RUN) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        if (act_mode_q) begin
                            idx_d = '0;
                            cnt_d = period_ld(act_freq_q[0]);
                            ser_d = act_out_q[0];
                        end else begin
                            ch_state_d = CH_IDLE;
                            ser_d      = 1'b0;
                        end
                    end else begin
                        idx_d = nxt_idx;
                        cnt_d = period_ld(act_freq_q[nxt_idx]);
                        ser_d = act_out_q[nxt_idx];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ch_state_q <= CH_IDLE;
                    act_out_q  <= '0;
                    act_freq_q <= '0;
                    act_mode_q <= 1'b0;
                    idx_q      <= '0;
                    cnt_q      <= '0;
                    ser_q      <= 1'b0;
                    done_q     <= 1'b0;
                end else begin
                    ch_state_q <= ch_state_d;
                    act_out_q  <= act_out_d;
                    act_freq_q <= act_freq_d;
                    act_mode_q <= act_mode_d;
                    idx_q      <= idx_d;
                    cnt_q      <= cnt_d;
                    ser_q      <= ser_d;
                    done_q     <= done_d;
                end
            end

            assign o_serial_out[gi] = ser_q;
            assign o_busy[gi]       = (ch_state_q == CH_RUN);
            assign o_done_tick[gi]  = done_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_ch_pattern_engine.sv
// Directed bench for multi_ch_pattern_engine: vector tables walked against a
// cycle counter, plus hand sequences for stop/commit, shadow and reset corners.
module tb_multi_ch_pattern_engine;

    localparam int DB = 32;
    localparam int CN = 16;
    localparam int CB = 5;
    localparam int FD = 4;
    localparam int SD = 16;
    localparam int DV = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [CB-1:0] i_cfg_sel;
    logic [DB-1:0] i_cfg_output;
    logic [DB-1:0] i_cfg_freq;
    logic          i_cfg_mode;
    logic          i_cfg_arm;
    logic          i_commit;
    logic [CN-1:0] i_stop;
    logic [CN-1:0] o_serial_out;
    logic [CN-1:0] o_busy;
    logic [CN-1:0] o_done_tick;

    multi_ch_pattern_engine #(
        .DATA_BIT(DB), .CH_NUM(CN), .CH_BIT(CB),
        .FAST_DIV(FD), .SLOW_DIV(SD), .DIV_BIT(DV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_sel(i_cfg_sel), .i_cfg_output(i_cfg_output),
        .i_cfg_freq(i_cfg_freq), .i_cfg_mode(i_cfg_mode),
        .i_cfg_arm(i_cfg_arm), .i_commit(i_commit), .i_stop(i_stop),
        .o_serial_out(o_serial_out), .o_busy(o_busy), .o_done_tick(o_done_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic [CN-1:0] out;
        logic [CN-1:0] busy;
        logic [CN-1:0] done;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;

    task automatic chk(input string name, input logic [CN-1:0] act, input logic [CN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [CN-1:0] out,
                           input logic [CN-1:0] busy, input logic [CN-1:0] done);
        chk({name, "_out"}, o_serial_out, out);
        chk({name, "_busy"}, o_busy, busy);
        chk({name, "_done"}, o_done_tick, done);
    endtask

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    task automatic cfg_write(input int sel, input logic [DB-1:0] o, input logic [DB-1:0] f,
                             input logic m, input logic a);
        i_cfg_valid  = 1'b1;
        i_cfg_sel    = CB'(sel);
        i_cfg_output = o;
        i_cfg_freq   = f;
        i_cfg_mode   = m;
        i_cfg_arm    = a;
        chk("cfg_ready", CN'(o_cfg_ready), 16'h1);
        tick();
        i_cfg_valid = 1'b0;
        $display("cfg sel=%0d out=%h freq=%h mode=%0d arm=%0d", sel, o, f, m, a);
    endtask

    // Pulses commit and returns at the first cycle a started channel shows bit 0 (t=0).
    task automatic commit_start(input logic [CN-1:0] busy_pre);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        chk("ready_in_commit", CN'(o_cfg_ready), 16'h0);
        chk("busy_in_commit", o_busy, busy_pre);
        tick();
        t = 0;
        chk("ready_after_commit", CN'(o_cfg_ready), 16'h1);
        $display("commit issued");
    endtask

    task automatic run_vectors(input string tag);
        foreach (vq[i]) begin
            while (t < vq[i].t) tick();
            chk_all(tag, vq[i].out, vq[i].busy, vq[i].done);
            $display("%s vec t=%0d out=%h busy=%h done=%h", tag, t, o_serial_out, o_busy, o_done_tick);
        end
        vq.delete();
    endtask

    initial begin
        rst_n = 1'b0; i_cfg_valid = 1'b0; i_cfg_sel = '0; i_cfg_output = '0;
        i_cfg_freq = '0; i_cfg_mode = 1'b0; i_cfg_arm = 1'b0; i_commit = 1'b0; i_stop = '0;
        repeat (2) @(negedge clk);
        chk_all("reset", 16'h0, 16'h0, 16'h0);
        chk("reset_ready", CN'(o_cfg_ready), 16'h1);
        rst_n = 1'b1;
        repeat (4) tick();
        chk_all("post_reset_idle", 16'h0, 16'h0, 16'h0);

        // One-shot on ch3: bits 0-15 fast (4 cycles), 16-31 slow (16 cycles).
        cfg_write(3, 32'hA5A5A5A5, 32'h0000FFFF, 1'b0, 1'b1);
        commit_start(16'h0);
        vq.push_back('{t:0,   out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:3,   out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:4,   out:16'h0000, busy:16'h0008, done:16'h0});
        vq.push_back('{t:8,   out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:12,  out:16'h0000, busy:16'h0008, done:16'h0});
        vq.push_back('{t:16,  out:16'h0000, busy:16'h0008, done:16'h0});
        vq.push_back('{t:20,  out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:63,  out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:64,  out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:79,  out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:80,  out:16'h0000, busy:16'h0008, done:16'h0});
        vq.push_back('{t:96,  out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:319, out:16'h0008, busy:16'h0008, done:16'h0});
        vq.push_back('{t:320, out:16'h0000, busy:16'h0000, done:16'h0008});
        vq.push_back('{t:321, out:16'h0000, busy:16'h0000, done:16'h0});
        run_vectors("oneshot");

        // ch0 and ch15 repeat, all bits fast: 128-cycle frames, aligned start.
        cfg_write(0,  32'h00000003, 32'hFFFFFFFF, 1'b1, 1'b1);
        cfg_write(15, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
        commit_start(16'h0);
        vq.push_back('{t:0,   out:16'h8001, busy:16'h8001, done:16'h0});
        vq.push_back('{t:3,   out:16'h8001, busy:16'h8001, done:16'h0});
        vq.push_back('{t:4,   out:16'h0001, busy:16'h8001, done:16'h0});
        vq.push_back('{t:8,   out:16'h0000, busy:16'h8001, done:16'h0});
        vq.push_back('{t:127, out:16'h0000, busy:16'h8001, done:16'h0});
        vq.push_back('{t:128, out:16'h8001, busy:16'h8001, done:16'h8001});
        vq.push_back('{t:129, out:16'h8001, busy:16'h8001, done:16'h0});
        vq.push_back('{t:256, out:16'h8001, busy:16'h8001, done:16'h8001});
        vq.push_back('{t:257, out:16'h8001, busy:16'h8001, done:16'h0});
        run_vectors("aligned");
        i_stop = 16'h8001;
        tick();
        i_stop = '0;
        chk_all("stop_repeat", 16'h0, 16'h0, 16'h0);
        $display("stop ch0/ch15 busy=%h", o_busy);

        // ch5 repeat, then re-arm and stop on the edge that ends S_COMMIT.
        cfg_write(5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        commit_start(16'h0);
        chk_all("ch5_start", 16'h0020, 16'h0020, 16'h0);
        repeat (5) tick();
        cfg_write(5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        chk("collide_ready", CN'(o_cfg_ready), 16'h0);
        i_stop = 16'h0020;
        tick();
        i_stop = '0;
        chk_all("stop_wins", 16'h0, 16'h0, 16'h0);
        $display("collision busy=%h out=%h", o_busy, o_serial_out);
        repeat (3) tick();
        chk_all("stop_wins_hold", 16'h0, 16'h0, 16'h0);
        commit_start(16'h0);
        chk_all("arm_cleared", 16'h0, 16'h0, 16'h0);
        tick();
        chk_all("arm_cleared2", 16'h0, 16'h0, 16'h0);

        // ch2 runs; new unarmed shadow and an out-of-range select must not affect it.
        cfg_write(2, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
        commit_start(16'h0);
        chk_all("ch2_start", 16'h0004, 16'h0004, 16'h0);
        while (t < 10) tick();
        cfg_write(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        while (t < 12) tick();
        chk_all("shadow_iso", 16'h0, 16'h0004, 16'h0);
        cfg_write(CN, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        while (t < 20) tick();
        commit_start(16'h0004);
        // ch2 frame time is now t+22.
        chk_all("no_restart", 16'h0, 16'h0004, 16'h0);
        vq.push_back('{t:105, out:16'h0000, busy:16'h0004, done:16'h0});
        vq.push_back('{t:106, out:16'h0004, busy:16'h0004, done:16'h0004});
        vq.push_back('{t:107, out:16'h0004, busy:16'h0004, done:16'h0});
        run_vectors("old_frame");

        // Arm ch7, then reset asynchronously in the middle of S_COMMIT.
        cfg_write(7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 16'h0, 16'h0, 16'h0);
        chk("async_reset_ready", CN'(o_cfg_ready), 16'h1);
        $display("async reset out=%h busy=%h ready=%0d", o_serial_out, o_busy, o_cfg_ready);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk_all("after_reset", 16'h0, 16'h0, 16'h0);
        commit_start(16'h0);
        chk_all("reset_cleared_arm", 16'h0, 16'h0, 16'h0);
        repeat (4) tick();
        chk_all("reset_cleared_arm2", 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_ch_pattern_engine.md
Name: multi_ch_pattern_engine

Overview:
Parametrised successor of the 16-channel differential-frequency serial output block. It has CH_NUM channels, each with its own serializer and programmable FAST/SLOW bit periods. Configuration arrives over a valid/ready interface into per-channel shadow registers. An explicit commit applies all armed channels in the same cycle, so several channels start phase-aligned. Each channel also has its own stop, busy and done status.

Parameters:
DATA_BIT, 32, pattern length in bits per channel
CH_NUM, 16, number of output channels (2..32)
CH_BIT, 4, width of the channel select; must satisfy 2**CH_BIT >= CH_NUM
FAST_DIV, 4, clk cycles per bit when the freq bit is 1 (>=1)
SLOW_DIV, 16, clk cycles per bit when the freq bit is 0 (>=1)
DIV_BIT, 8, bit-period counter width; must hold max(FAST_DIV,SLOW_DIV)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
i_cfg_valid  in  1  config word valid
o_cfg_ready  out  1  config word accepted when valid&ready
i_cfg_sel  in  CH_BIT  target channel
i_cfg_output  in  DATA_BIT  output pattern, transmitted LSB first
i_cfg_freq  in  DATA_BIT  per-bit period select: 1=FAST_DIV, 0=SLOW_DIV
i_cfg_mode  in  1  0=one-shot, 1=repeat
i_cfg_arm  in  1  1=include this channel in the next commit
i_commit  in  1  pulse; starts all armed channels together
i_stop  in  CH_NUM  per-channel stop pulse
o_serial_out  out  CH_NUM  serial outputs; idle level low
o_busy  out  CH_NUM  channel running
o_done_tick  out  CH_NUM  1-cycle pulse at the end of each frame

Behaviour:
- Reset (async, rst_n=0): all shadow and active registers, arm bits and counters are cleared. Control FSM=S_IDLE. o_serial_out=0, o_busy=0, o_done_tick=0, o_cfg_ready=1.
- Control FSM states: S_IDLE and S_COMMIT.
  - S_IDLE: o_cfg_ready=1. i_commit=1 moves the FSM to S_COMMIT.
  - S_COMMIT: lasts exactly 1 cycle, o_cfg_ready=0, i_commit is ignored. Returns to S_IDLE.
- Config accept (valid&ready): writes shadow[sel] = {output, freq, mode} and arm[sel] = i_cfg_arm.
  - A word with sel >= CH_NUM is accepted and discarded.
  - Shadow writes never disturb a running channel.
- Config and i_commit in the same S_IDLE cycle: the word lands in shadow and is included in that commit.
- At the clock edge ending S_COMMIT, for each armed channel:
  - active <= shadow and the channel (re)starts at bit 0.
  - All arm bits are cleared.
  - Unarmed channels are untouched.
  - A running armed channel restarts immediately; no done_tick is issued for the aborted frame.
- Latency: i_commit sampled at edge N; bit 0 appears on o_serial_out after edge N+1; o_busy rises at the same edge.
- Channel engine (per channel, states CH_IDLE and CH_RUN):
  - Bit k is held for FAST_DIV cycles if freq[k]=1, otherwise SLOW_DIV cycles. o_serial_out is registered.
  - After bit DATA_BIT-1 completes, o_done_tick pulses for 1 cycle.
  - One-shot: go to CH_IDLE, output low, o_busy=0 in the same cycle as the done_tick.
  - Repeat: wrap to bit 0 with no gap cycle; o_busy stays 1.
- Stop: i_stop[c]=1 forces channel c to CH_IDLE at the next edge, output low, no done_tick.
  - Stop on an idle channel has no effect.
  - Stop and commit-restart on the same channel at the same edge: stop wins, the channel stays idle, and its arm bit is still cleared.
  - Stop coinciding with frame end: stop wins, no done_tick.
- Counters: the bit index wraps at DATA_BIT-1 and the period counter reloads per bit. No arithmetic overflow is possible given the parameter constraints.
- Reset mid-frame: outputs go low immediately (asynchronous). No done_tick is issued.

Test Plan:
1. Reset defaults: assert rst_n=0 mid-run. Required: o_serial_out=0, o_busy=0 and o_cfg_ready=1 with no clock edge. After release, with no config, all outputs stay 0.
2. Single one-shot, DATA_BIT=32, FAST_DIV=4, SLOW_DIV=16: write ch3 output=0xA5A5A5A5, freq=0x0000FFFF, mode=0, arm=1, then commit.
   - Required: out3 shows bit 0 two edges after the commit sample.
   - Bits 0-15 last 4 cycles each, bits 16-31 last 16 cycles each; frame = 320 cycles.
   - done3 is a 1-cycle pulse at the end; busy3 then falls and out3=0.
3. Aligned start: arm ch0 and ch15 with different patterns and mode=1, commit.
   - Required: both channels' bit 0 starts on the same edge.
   - With freq=0xFFFFFFFF, done pulses repeat every 128 cycles with no idle gap.
4. Stop/commit collision: ch5 running in repeat; re-arm ch5 and assert i_stop[5] on the edge that ends S_COMMIT.
   - Required: ch5 goes idle and low, no done pulse, arm cleared.
   - A following commit does not start ch5.
5. Shadow isolation and handshake:
   - While ch2 runs, write new shadow for ch2 with arm=0. Required: ch2 pattern is unchanged; a commit leaves ch2 running its old frame.
   - Required: o_cfg_ready=0 for exactly the S_COMMIT cycle.
   - sel=CH_NUM is accepted and has no effect on any channel.
